// File: rtl/interrupt_sequencer.sv
// ---------------------------------------------------------------------------
// interrupt_sequencer
//
// Runs the 6502 reset, NMI, IRQ and (optionally) BRK entry sequences on the
// shared address/data datapath.  It sits beside the instruction decoder,
// samples pending events at each instruction boundary, and while a sequence
// is running it owns the bus (busy = 1).  A sequence is three stack cycles,
// two vector reads, and one PC load cycle.
//
// Optional feature:
//   INT_SEQ_BRK_EN  - when defined, brk_req sampled at an instruction
//                     boundary starts a BRK sequence (lowest priority), which
//                     pushes P with B = 1 and uses vector FFFE.  When
//                     undefined, brk_req is ignored and the pushed B is 0.
//
// Parameters:
//   STACK_PAGE     - high byte of every stack address (default 8'h01)
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   res            in   RES request, active-high level
//   nmi            in   NMI request, rising-edge sensitive
//   irq            in   IRQ request, active-high level (masked by I)
//   brk_req        in   BRK opcode decoded (only with INT_SEQ_BRK_EN)
//   rdy            in   1 = advance, 0 = freeze state/outputs, no effects
//   insn_boundary  in   decoder is about to enter opcode fetch
//   p_in[6:0]      in   status register {N,V,B,D,I,Z,C}
//   pc_in[15:0]    in   current program counter
//   sp_in[7:0]     in   current stack pointer
//   data_in[7:0]   in   data bus read value
//   busy           out  sequence active, decoder must idle
//   addr_out[15:0] out  bus address while busy
//   data_out[7:0]  out  bus write data
//   rw             out  1 = read, 0 = write
//   sp_dec         out  decrement SP at this edge
//   set_i          out  set the I flag at this edge
//   pc_load        out  load PC from pc_load_value at this edge
//   pc_load_value  out  vector {hi, lo}
//   int_ack[1:0]   out  pulse with pc_load: 01 RES, 10 NMI, 11 IRQ/BRK
//   dbg_state[2:0] out  current FSM state encoding (observation only)
//
// Handshake: there is no valid/ready pair here; rdy is a global advance
// enable.  When rdy is low the FSM, the vector latches and every bus output
// hold their value and the strobes sp_dec/set_i/pc_load/int_ack are forced
// low so the core sees no side effects.  Pending-event capture (res, nmi
// edges) keeps running while rdy is low so no request is lost.
// ---------------------------------------------------------------------------
module interrupt_sequencer #(
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        res,
  input  logic        nmi,
  input  logic        irq,
  input  logic        brk_req,
  input  logic        rdy,
  input  logic        insn_boundary,
  input  logic [6:0]  p_in,
  input  logic [15:0] pc_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  data_in,
  output logic        busy,
  output logic [15:0] addr_out,
  output logic [7:0]  data_out,
  output logic        rw,
  output logic        sp_dec,
  output logic        set_i,
  output logic        pc_load,
  output logic [15:0] pc_load_value,
  output logic [1:0]  int_ack,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RES_HOLD = 3'd1,
    S_PUSH_PCH = 3'd2,
    S_PUSH_PCL = 3'd3,
    S_PUSH_P   = 3'd4,
    S_VEC_LO   = 3'd5,
    S_VEC_HI   = 3'd6,
    S_LOAD_PC  = 3'd7
  } state_t;

  // Sequence kind is encoded directly as its acknowledge code so int_ack is
  // a plain copy.  BRK shares the IRQ code and is told apart by brk_q.
  localparam logic [1:0] K_RES = 2'b01;
  localparam logic [1:0] K_NMI = 2'b10;
  localparam logic [1:0] K_IRQ = 2'b11;

  state_t      state_q, state_d;
  logic [1:0]  kind_q, kind_d;
  logic        brk_q, brk_d;
  logic [7:0]  lo_q, hi_q;
  logic        nmi_q;
  logic        nmi_pend_q, nmi_pend_d;
  logic        res_pend_q, res_pend_d;

  logic        nmi_rise;
  logic        nmi_want;
  logic        irq_take;
  logic        nmi_clear;
  logic        res_done;
  logic [15:0] vec_base;
  logic [7:0]  pushed_p;
  logic [7:0]  push_byte;

  // p_in[4] (the live B bit) is never pushed: the stacked B is a property of
  // the sequence kind, not of the register.
  logic        unused_bits;
  assign unused_bits = ^{p_in[4], brk_req};

  // -------------------------------------------------------------------------
  // Event capture
  // -------------------------------------------------------------------------
  assign nmi_rise = nmi & ~nmi_q;
  // A rising edge in the very cycle the boundary is sampled still counts.
  assign nmi_want = nmi_pend_q | nmi_rise;
  assign irq_take = irq & ~p_in[2];

  // NMI is consumed when an NMI sequence (native or hijacked) enters VEC_LO;
  // any edge seen in VEC_LO or later stays pending for the next boundary.
  assign nmi_clear = (state_q == S_PUSH_P) && (state_d == S_VEC_LO) &&
                     (kind_d == K_NMI);

  assign res_done  = rdy && (state_q == S_LOAD_PC) && (kind_q == K_RES);

  always_comb begin
    nmi_pend_d = nmi_pend_q | nmi_rise;
    if (nmi_clear) begin
      nmi_pend_d = 1'b0;
    end
  end

  always_comb begin
    res_pend_d = res | (res_pend_q & ~res_done);
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      kind_q  <= K_RES;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      brk_q   <= brk_d;
    end
  end

  // Pending flags and vector latches.  res_pend comes out of reset set so the
  // first cycle after rst_n rises launches the reset sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_q      <= 1'b0;
      nmi_pend_q <= 1'b0;
      res_pend_q <= 1'b1;
      lo_q       <= 8'h00;
      hi_q       <= 8'h00;
    end else begin
      nmi_q      <= nmi;
      nmi_pend_q <= nmi_pend_d;
      res_pend_q <= res_pend_d;
      if (rdy && (state_q == S_VEC_LO)) begin
        lo_q <= data_in;
      end
      if (rdy && (state_q == S_VEC_HI)) begin
        hi_q <= data_in;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    brk_d   = brk_q;
    if (rdy) begin
      if (res) begin
        // RES overrides whatever is in flight and parks until released.
        state_d = S_RES_HOLD;
        kind_d  = K_RES;
        brk_d   = 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (res_pend_q) begin
              // Reset does not wait for an instruction boundary.
              state_d = S_PUSH_PCH;
              kind_d  = K_RES;
              brk_d   = 1'b0;
            end else if (insn_boundary) begin
              if (nmi_want) begin
                state_d = S_PUSH_PCH;
                kind_d  = K_NMI;
                brk_d   = 1'b0;
              end else if (irq_take) begin
                state_d = S_PUSH_PCH;
                kind_d  = K_IRQ;
                brk_d   = 1'b0;
              end
`ifdef INT_SEQ_BRK_EN
              else if (brk_req) begin
                state_d = S_PUSH_PCH;
                kind_d  = K_IRQ;
                brk_d   = 1'b1;
              end
`endif
            end
          end
          S_RES_HOLD: state_d = S_PUSH_PCH;
          S_PUSH_PCH: state_d = S_PUSH_PCL;
          S_PUSH_PCL: state_d = S_PUSH_P;
          S_PUSH_P: begin
            state_d = S_VEC_LO;
            // NMI hijack: an NMI that shows up before the vector fetch
            // redirects an IRQ/BRK sequence to the NMI vector.  The already
            // stacked B value is kept, as on the real part.
            if ((kind_q == K_IRQ) && nmi_want) begin
              kind_d = K_NMI;
            end
          end
          S_VEC_LO:  state_d = S_VEC_HI;
          S_VEC_HI:  state_d = S_LOAD_PC;
          S_LOAD_PC: state_d = S_IDLE;
          default:   state_d = S_IDLE;
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM: output logic
  // -------------------------------------------------------------------------
  always_comb begin
    unique case (kind_q)
      K_RES:   vec_base = 16'hFFFC;
      K_NMI:   vec_base = 16'hFFFA;
      default: vec_base = 16'hFFFE;
    endcase
  end

  // Stacked status: bit 5 always reads 1, bit 4 marks a software BRK.
  assign pushed_p = {p_in[6], p_in[5], 1'b1, brk_q, p_in[3:0]};

  always_comb begin
    busy          = (state_q != S_IDLE);
    addr_out      = 16'h0000;
    data_out      = 8'h00;
    rw            = 1'b1;
    sp_dec        = 1'b0;
    set_i         = 1'b0;
    pc_load       = 1'b0;
    int_ack       = 2'b00;
    pc_load_value = {hi_q, lo_q};
    push_byte     = 8'h00;

    unique case (state_q)
      S_PUSH_PCH: push_byte = pc_in[15:8];
      S_PUSH_PCL: push_byte = pc_in[7:0];
      S_PUSH_P:   push_byte = pushed_p;
      default:    push_byte = 8'h00;
    endcase

    unique case (state_q)
      S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P: begin
        addr_out = {STACK_PAGE, sp_in};
        sp_dec   = rdy;
        // Reset walks the stack with reads so memory is left untouched.
        if (kind_q == K_RES) begin
          rw       = 1'b1;
          data_out = 8'h00;
        end else begin
          rw       = 1'b0;
          data_out = push_byte;
        end
      end
      S_VEC_LO: begin
        addr_out = vec_base;
        set_i    = rdy;
      end
      S_VEC_HI: begin
        addr_out = vec_base + 16'd1;
      end
      S_LOAD_PC: begin
        pc_load = rdy;
        int_ack = rdy ? kind_q : 2'b00;
      end
      default: begin
        addr_out = 16'h0000;
      end
    endcase
  end

  assign dbg_state = state_q;

endmodule
